// File: rtl/bitstream_loader.sv
// Streams a byte-memory bitstream into the fabric config port as 32-bit words, then pulses the user reset.
// Per-word period is 5 + SETUP_CYC + 1 + GAP_CYC cycles; no backpressure, and abort/reset cancel a load at once.
module bitstream_loader #(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned GAP_CYC    = 2,
  parameter int unsigned SETTLE_CYC = 100,
  parameter int unsigned URST_CYC   = 5
) (
  input  logic        CLK,
  input  logic        resetn,
  input  logic        start,
  input  logic        abort,
  input  logic [14:0] byte_count,
  output logic        mem_rd,
  output logic [13:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic [31:0] SelfWriteData,
  output logic        SelfWriteStrobe,
  output logic        user_rst,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, FETCH, SETUP, STROBE, GAP, SETTLE, URST, DONE} state_t;

  localparam logic [15:0] SETUP_LAST  = 16'(SETUP_CYC - 1);
  localparam logic [15:0] GAP_LAST    = 16'(GAP_CYC - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] URST_LAST   = 16'(URST_CYC - 1);

  state_t      state, nstate;
  logic [15:0] cnt, ncnt;
  logic [13:0] base, nbase;
  logic [12:0] words, nwords;
  logic [14:0] byte_lim, nbyte_lim;
  logic        nerr;
  logic [31:0] shreg;
  logic        rd_q;
  logic [7:0]  cap_byte;
  logic        mem_rd_n, strobe_n, user_rst_n, busy_n, done_n;
  logic [13:0] mem_addr_n;
  logic [31:0] swd_n;

  // Slots past the end of the bitstream were never read, so they contribute zero.
  assign cap_byte = rd_q ? mem_rdata : 8'h00;

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      base     <= '0;
      words    <= '0;
      byte_lim <= '0;
      shreg    <= '0;
      rd_q     <= 1'b0;
    end else begin
      state    <= nstate;
      cnt      <= ncnt;
      base     <= nbase;
      words    <= nwords;
      byte_lim <= nbyte_lim;
      rd_q     <= mem_rd;
      if (state == FETCH && cnt != 16'd0) shreg <= {shreg[23:0], cap_byte};
    end
  end

  always_comb begin
    nstate    = state;
    ncnt      = cnt + 16'd1;
    nbase     = base;
    nwords    = words;
    nbyte_lim = byte_lim;
    nerr      = err;
    if (state == IDLE || state == DONE) begin
      ncnt = '0;
      if (start && !abort) begin
        nerr      = 1'b0;
        nbyte_lim = byte_count;
        if (byte_count == 15'd0 || byte_count > 15'd16384) begin
          nstate = DONE;
          nerr   = 1'b1;
        end else begin
          nstate = FETCH;
          nbase  = '0;
          nwords = 13'((byte_count + 15'd3) >> 2);
        end
      end
    end else if (abort) begin
      nstate = IDLE;
      ncnt   = '0;
      nerr   = 1'b1;
    end else begin
      case (state)
        FETCH:  if (cnt == 16'd4)      begin nstate = SETUP;  ncnt = '0; end
        SETUP:  if (cnt == SETUP_LAST) begin nstate = STROBE; ncnt = '0; end
        STROBE: begin nstate = GAP; ncnt = '0; end
        GAP: if (cnt == GAP_LAST) begin
          ncnt   = '0;
          nwords = words - 13'd1;
          if (words == 13'd1) begin
            nstate = SETTLE;
          end else begin
            nstate = FETCH;
            nbase  = base + 14'd4;
          end
        end
        SETTLE: if (cnt == SETTLE_LAST) begin nstate = URST; ncnt = '0; end
        URST:   if (cnt == URST_LAST)   begin nstate = DONE; ncnt = '0; end
        default: nstate = IDLE;
      endcase
    end
  end

  // Output values are computed from the next state so every port comes straight off a flop.
  always_comb begin
    mem_rd_n   = (nstate == FETCH) && (ncnt < 16'd4) &&
                 ({1'b0, nbase + 14'(ncnt[1:0])} < nbyte_lim);
    mem_addr_n = mem_addr;
    if (nstate == FETCH && ncnt < 16'd4) mem_addr_n = nbase + 14'(ncnt[1:0]);
    swd_n = SelfWriteData;
    if (state == FETCH && nstate == SETUP) swd_n = {shreg[23:0], cap_byte};
    strobe_n   = (nstate == STROBE);
    user_rst_n = (nstate == URST);
    busy_n     = !(nstate == IDLE || nstate == DONE);
    done_n     = (nstate == DONE);
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      mem_rd          <= 1'b0;
      mem_addr        <= '0;
      SelfWriteData   <= '0;
      SelfWriteStrobe <= 1'b0;
      user_rst        <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
    end else begin
      mem_rd          <= mem_rd_n;
      mem_addr        <= mem_addr_n;
      SelfWriteData   <= swd_n;
      SelfWriteStrobe <= strobe_n;
      user_rst        <= user_rst_n;
      busy            <= busy_n;
      done            <= done_n;
      err             <= nerr;
    end
  end

endmodule

// File: tb/tb_bitstream_loader.sv
// Directed bench for bitstream_loader with a one-cycle-latency byte memory model.
module tb_bitstream_loader;
  logic        CLK = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [14:0] byte_count = '0;
  logic        mem_rd;
  logic [13:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic [31:0] SelfWriteData;
  logic        SelfWriteStrobe, user_rst, busy, done, err;

  int n_chk = 0;
  int n_fail = 0;

  bitstream_loader dut (
    .CLK(CLK), .resetn(resetn), .start(start), .abort(abort), .byte_count(byte_count),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .SelfWriteData(SelfWriteData), .SelfWriteStrobe(SelfWriteStrobe),
    .user_rst(user_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  logic [7:0] mem [0:16383];
  // Unread cycles return a poison byte so zero-fill of short words is really tested.
  always @(posedge CLK) mem_rdata <= mem_rd ? mem[mem_addr] : 8'hEE;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [31:0] stb_dat[$];
  int          stb_t[$];
  int          rd_cnt = 0, urst_cnt = 0, urst_t = 0, overlap = 0;
  logic [13:0] last_rd_addr = '0;
  logic        urst_prev = 1'b0;
  always @(negedge CLK) begin
    if (SelfWriteStrobe) begin
      stb_dat.push_back(SelfWriteData);
      stb_t.push_back(cyc);
    end
    if (mem_rd) begin
      rd_cnt <= rd_cnt + 1;
      last_rd_addr <= mem_addr;
    end
    if (user_rst) begin
      urst_cnt <= urst_cnt + 1;
      if (!urst_prev) urst_t <= cyc;
    end
    if (SelfWriteStrobe && user_rst) overlap <= overlap + 1;
    urst_prev <= user_rst;
  end

  task automatic start_load(input logic [14:0] bc, output int t0);
    @(posedge CLK); #1;
    byte_count = bc;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge CLK);
      n++;
    end
    ok = done;
  endtask

  task automatic pulse_abort();
    @(posedge CLK); #1 abort = 1'b1;
    @(posedge CLK); #1 abort = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    #1;
    n_chk++;
    if ({mem_rd, mem_addr, SelfWriteData, SelfWriteStrobe, user_rst, busy, done, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rd=%b addr=%h dat=%h stb=%b urst=%b busy=%b done=%b err=%b, want all 0",
               mem_rd, mem_addr, SelfWriteData, SelfWriteStrobe, user_rst, busy, done, err);
    end
    repeat (3) @(posedge CLK);
    #1 resetn = 1'b1;
    repeat (3) @(negedge CLK);
    n_chk++;
    if ({busy, done, err, SelfWriteStrobe} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_release_idle: got busy/done/err/stb=%b want 0000", {busy, done, err, SelfWriteStrobe});
    end
  endtask

  task automatic test_two_words();
    int t0, sb, rb, ub; bit ok;
    for (int i = 0; i < 8; i++) mem[i] = 8'(i);
    sb = stb_dat.size(); rb = rd_cnt; ub = urst_cnt;
    start_load(15'd8, t0);
    @(negedge CLK);
    n_chk++;
    if ({busy, mem_rd, mem_addr} !== {1'b1, 1'b1, 14'd0}) begin
      n_fail++;
      $display("FAIL first_fetch: got busy=%b rd=%b addr=%0d want 1 1 0", busy, mem_rd, mem_addr);
    end
    wait_done(400, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL two_words_done: got done=%b want 1", done); end
    n_chk++;
    if (stb_dat.size() - sb !== 2) begin n_fail++; $display("FAIL two_words_count: got %0d strobes want 2", stb_dat.size() - sb); end
    n_chk++;
    if (stb_dat[sb] !== 32'h00010203) begin n_fail++; $display("FAIL word0: got %h want 00010203", stb_dat[sb]); end
    n_chk++;
    if (stb_dat[sb+1] !== 32'h04050607) begin n_fail++; $display("FAIL word1: got %h want 04050607", stb_dat[sb+1]); end
    n_chk++;
    if (stb_t[sb] - t0 !== 7) begin n_fail++; $display("FAIL first_strobe_lat: got %0d want 7", stb_t[sb] - t0); end
    n_chk++;
    if (stb_t[sb+1] - stb_t[sb] !== 10) begin n_fail++; $display("FAIL word_period: got %0d want 10", stb_t[sb+1] - stb_t[sb]); end
    n_chk++;
    if (urst_cnt - ub !== 5) begin n_fail++; $display("FAIL urst_len: got %0d want 5", urst_cnt - ub); end
    n_chk++;
    if (urst_t - stb_t[sb+1] !== 103) begin n_fail++; $display("FAIL urst_start: got %0d want 103", urst_t - stb_t[sb+1]); end
    n_chk++;
    if ({done, err, busy} !== 3'b100) begin n_fail++; $display("FAIL two_words_flags: got done/err/busy=%b want 100", {done, err, busy}); end
    n_chk++;
    if (rd_cnt - rb !== 8) begin n_fail++; $display("FAIL two_words_reads: got %0d want 8", rd_cnt - rb); end
    n_chk++;
    if (overlap !== 0) begin n_fail++; $display("FAIL strobe_urst_overlap: got %0d want 0", overlap); end
  endtask

  task automatic test_partial();
    int t0, sb, rb; bit ok;
    for (int i = 0; i < 8; i++) mem[i] = 8'hAA;
    sb = stb_dat.size(); rb = rd_cnt;
    start_load(15'd6, t0);
    wait_done(400, ok);
    n_chk++;
    if (!ok || stb_dat.size() - sb !== 2) begin
      n_fail++; $display("FAIL partial_count: got done=%b strobes=%0d want 1 2", done, stb_dat.size() - sb);
    end
    n_chk++;
    if (stb_dat[sb] !== 32'hAAAAAAAA) begin n_fail++; $display("FAIL partial_word0: got %h want aaaaaaaa", stb_dat[sb]); end
    n_chk++;
    if (stb_dat[sb+1] !== 32'hAAAA0000) begin n_fail++; $display("FAIL partial_word1: got %h want aaaa0000", stb_dat[sb+1]); end
    n_chk++;
    if (rd_cnt - rb !== 6) begin n_fail++; $display("FAIL partial_reads: got %0d want 6", rd_cnt - rb); end
    n_chk++;
    if (last_rd_addr !== 14'd5) begin n_fail++; $display("FAIL partial_last_addr: got %0d want 5", last_rd_addr); end
  endtask

  task automatic test_bad_count();
    int t0, sb, rb;
    logic [14:0] bad [3];
    bad[0] = 15'd0; bad[1] = 15'd20000; bad[2] = 15'd16385;
    sb = stb_dat.size(); rb = rd_cnt;
    for (int k = 0; k < 3; k++) begin
      start_load(bad[k], t0);
      @(negedge CLK);
      n_chk++;
      if ({done, err, busy} !== 3'b110) begin
        n_fail++; $display("FAIL bad_count_%0d: got done/err/busy=%b want 110", bad[k], {done, err, busy});
      end
      repeat (20) @(negedge CLK);
    end
    n_chk++;
    if (stb_dat.size() - sb !== 0 || rd_cnt - rb !== 0) begin
      n_fail++; $display("FAIL bad_count_activity: got strobes=%0d reads=%0d want 0 0", stb_dat.size() - sb, rd_cnt - rb);
    end
    start_load(15'd16384, t0);
    @(negedge CLK);
    n_chk++;
    if ({busy, err, mem_rd} !== 3'b101) begin
      n_fail++; $display("FAIL max_count_accept: got busy/err/rd=%b want 101", {busy, err, mem_rd});
    end
    pulse_abort();
    n_chk++;
    if ({busy, err, done} !== 3'b010) begin
      n_fail++; $display("FAIL max_count_abort: got busy/err/done=%b want 010", {busy, err, done});
    end
  endtask

  task automatic test_abort();
    int t0, sb, ub, n0;
    for (int i = 0; i < 8; i++) mem[i] = 8'(i);
    sb = stb_dat.size(); ub = urst_cnt;
    start_load(15'd8, t0);
    repeat (13) @(posedge CLK);
    #1 abort = 1'b1;
    @(posedge CLK); #1 abort = 1'b0;
    @(negedge CLK);
    n_chk++;
    if ({busy, err, done, mem_rd, SelfWriteStrobe, user_rst} !== 6'b010000) begin
      n_fail++; $display("FAIL abort_next: got busy/err/done/rd/stb/urst=%b want 010000",
                         {busy, err, done, mem_rd, SelfWriteStrobe, user_rst});
    end
    repeat (150) @(negedge CLK);
    n_chk++;
    if (stb_dat.size() - sb !== 1 || urst_cnt - ub !== 0) begin
      n_fail++; $display("FAIL abort_after: got strobes=%0d urst=%0d want 1 0", stb_dat.size() - sb, urst_cnt - ub);
    end
    pulse_abort();
    n_chk++;
    if ({busy, err, done} !== 3'b010) begin
      n_fail++; $display("FAIL abort_in_idle: got busy/err/done=%b want 010", {busy, err, done});
    end
    n0 = stb_dat.size();
    @(posedge CLK); #1;
    byte_count = 15'd8; start = 1'b1; abort = 1'b1;
    @(posedge CLK); #1 start = 1'b0; abort = 1'b0;
    repeat (20) @(negedge CLK);
    n_chk++;
    if ({busy, err} !== 2'b01 || stb_dat.size() !== n0) begin
      n_fail++; $display("FAIL start_with_abort: got busy/err=%b strobes=%0d want 01 0", {busy, err}, stb_dat.size() - n0);
    end
  endtask

  task automatic test_start_in_setup();
    int t0, sb; bit ok;
    sb = stb_dat.size();
    start_load(15'd8, t0);
    repeat (5) @(posedge CLK);
    #1 start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    wait_done(400, ok);
    n_chk++;
    if (!ok || stb_dat.size() - sb !== 2) begin
      n_fail++; $display("FAIL setup_start_count: got done=%b strobes=%0d want 1 2", done, stb_dat.size() - sb);
    end
    n_chk++;
    if (stb_t[sb] - t0 !== 7 || stb_t[sb+1] - t0 !== 17) begin
      n_fail++; $display("FAIL setup_start_timing: got %0d,%0d want 7,17", stb_t[sb] - t0, stb_t[sb+1] - t0);
    end
    n_chk++;
    if (stb_dat[sb] !== 32'h00010203 || stb_dat[sb+1] !== 32'h04050607) begin
      n_fail++; $display("FAIL setup_start_data: got %h,%h want 00010203,04050607", stb_dat[sb], stb_dat[sb+1]);
    end
  endtask

  task automatic test_reset_in_gap();
    int t0, sb, ub;
    sb = stb_dat.size(); ub = urst_cnt;
    start_load(15'd8, t0);
    repeat (8) @(posedge CLK);
    #1 resetn = 1'b0;
    #1;
    n_chk++;
    if ({mem_rd, mem_addr, SelfWriteData, SelfWriteStrobe, user_rst, busy, done, err} !== '0) begin
      n_fail++; $display("FAIL gap_reset_outputs: got rd=%b addr=%h dat=%h stb=%b urst=%b busy=%b done=%b err=%b, want all 0",
                         mem_rd, mem_addr, SelfWriteData, SelfWriteStrobe, user_rst, busy, done, err);
    end
    repeat (3) @(posedge CLK);
    #1 resetn = 1'b1;
    repeat (200) @(negedge CLK);
    n_chk++;
    if (stb_dat.size() - sb !== 1 || urst_cnt - ub !== 0 || {busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL gap_reset_after: got strobes=%0d urst=%0d busy/done=%b want 1 0 00",
                         stb_dat.size() - sb, urst_cnt - ub, {busy, done});
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    test_reset();
    test_two_words();
    test_partial();
    test_bad_count();
    test_abort();
    test_start_in_setup();
    test_reset_in_gap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
